// File: rtl/ulpi_op_assembler_pkg.sv
// Shared definitions for the ULPI operation assembler: FSM encoding, message size limits
// and a constant clog2 helper used for port and counter widths.
package ulpi_op_assembler_pkg;

  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned MSG_BYTES_MIN = 1;
  localparam int unsigned MSG_BYTES_MAX = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_PUSH = 2'd2
  } asm_state_e;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ulpi_op_fifo.sv
// Synchronous word FIFO with registered read data and registered full/empty/count.
// Pointers wrap modulo DEPTH (power of two); a read of an empty FIFO is ignored.
module ulpi_op_fifo
  import ulpi_op_assembler_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   wr_en_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  input  logic                   rd_en_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [clog2(DEPTH):0]  count_o
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             wr_ok_c, rd_ok_c;

  // Accept decisions use the flags registered before this edge.
  always_comb begin
    wr_ok_c = wr_en_i & ~full_q;
    rd_ok_c = rd_en_i & ~empty_q;
    count_d = count_q + CW'(wr_ok_c) - CW'(rd_ok_c);
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok_c) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      rd_data_q <= '0;
    end else begin
      if (wr_ok_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_ok_c) begin
        rd_ptr_q  <= rd_ptr_q + AW'(1);
        rd_data_q <= mem_q[rd_ptr_q];
      end
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  assign rd_data_o = rd_data_q;
  assign full_o    = full_q;
  assign empty_o   = empty_q;
  assign count_o   = count_q;

endmodule

// File: rtl/ulpi_op_assembler.sv
// Packs MSG_BYTES UART bytes (first byte in the top slot) into one word and queues it.
// Define ULPI_OP_ASM_TIMEOUT_EN to build the inter-byte idle timeout that discards partial messages.
module ulpi_op_assembler
  import ulpi_op_assembler_pkg::*;
#(
  parameter int unsigned MSG_BYTES      = 2,
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [BYTE_W-1:0]           uart_data,
  input  logic                        uart_rx_empty,
  output logic                        uart_nxt,
  input  logic                        op_pull,
  output logic [BYTE_W*MSG_BYTES-1:0] op_msg,
  output logic                        op_full,
  output logic                        op_empty,
  output logic [clog2(DEPTH):0]       op_count,
  output logic                        overflow,
  input  logic                        overflow_clr,
  output logic                        resync
);

  localparam int unsigned MSG_W = BYTE_W * MSG_BYTES;
  localparam int unsigned IDX_W = clog2(MSG_BYTES_MAX) + 1;

  asm_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [MSG_W-1:0] asm_q, asm_d;
  logic             ovf_q, ovf_d;
  logic             nxt_q;
  logic             push_c;

`ifdef ULPI_OP_ASM_TIMEOUT_EN
  localparam int unsigned TMO_W = clog2(TIMEOUT_CYCLES) + 1;

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             resync_q, resync_d;
`else
  // TIMEOUT_CYCLES has no effect when the idle counter is not built.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  // Next-state, byte slotting, push and overflow decisions.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    ovf_d   = ovf_q;
    push_c  = 1'b0;
`ifdef ULPI_OP_ASM_TIMEOUT_EN
    tmo_d    = tmo_q;
    resync_d = 1'b0;
`endif

    if (overflow_clr) ovf_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!uart_rx_empty) state_d = ST_READ;
`ifdef ULPI_OP_ASM_TIMEOUT_EN
        if (idx_q != '0) begin
          if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            tmo_d    = '0;
            idx_d    = '0;
            resync_d = 1'b1;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
`endif
      end
      ST_READ: begin
        for (int unsigned b = 0; b < MSG_BYTES; b++) begin
          if (idx_q == IDX_W'(b)) asm_d[MSG_W-1-BYTE_W*b -: BYTE_W] = uart_data;
        end
        idx_d   = idx_q + IDX_W'(1);
        state_d = (idx_q == IDX_W'(MSG_BYTES - 1)) ? ST_PUSH : ST_IDLE;
`ifdef ULPI_OP_ASM_TIMEOUT_EN
        tmo_d = '0;
`endif
      end
      ST_PUSH: begin
        // A drop outranks a same-cycle overflow_clr.
        if (op_full) ovf_d = 1'b1;
        else         push_c = 1'b1;
        idx_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      asm_q   <= '0;
      ovf_q   <= 1'b0;
      nxt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      ovf_q   <= ovf_d;
      nxt_q   <= (state_d == ST_READ);
    end
  end

`ifdef ULPI_OP_ASM_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q    <= '0;
      resync_q <= 1'b0;
    end else begin
      tmo_q    <= tmo_d;
      resync_q <= resync_d;
    end
  end

  assign resync = resync_q;
`else
  assign resync = 1'b0;
`endif

  assign uart_nxt = nxt_q;
  assign overflow = ovf_q;

  ulpi_op_fifo #(
    .WIDTH (MSG_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_ni    (rst),
    .wr_en_i   (push_c),
    .wr_data_i (asm_q),
    .rd_en_i   (op_pull),
    .rd_data_o (op_msg),
    .full_o    (op_full),
    .empty_o   (op_empty),
    .count_o   (op_count)
  );

endmodule

// File: tb/tb_ulpi_op_assembler.sv
// Bench for ulpi_op_assembler: two instances (2-byte and 4-byte messages) fed from byte queues,
// checked against a queue-based message model. Timeout expectations follow ULPI_OP_ASM_TIMEOUT_EN.
module tb_ulpi_op_assembler;

  localparam int unsigned A_BYTES = 2;
  localparam int unsigned B_BYTES = 4;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TMO     = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  a_data, b_data;
  logic        a_rxe = 1'b1, b_rxe = 1'b1;
  logic        a_pull = 1'b0, b_pull = 1'b0, a_clr = 1'b0, b_clr = 1'b0;
  logic        a_nxt, b_nxt, a_full, b_full, a_emp, b_emp, a_ovf, b_ovf, a_rsy, b_rsy;
  logic [15:0] a_msg;
  logic [31:0] b_msg;
  logic [2:0]  a_cnt, b_cnt;

  ulpi_op_assembler #(.MSG_BYTES(A_BYTES), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) u_a (
    .clk(clk), .rst(rst), .uart_data(a_data), .uart_rx_empty(a_rxe), .uart_nxt(a_nxt),
    .op_pull(a_pull), .op_msg(a_msg), .op_full(a_full), .op_empty(a_emp), .op_count(a_cnt),
    .overflow(a_ovf), .overflow_clr(a_clr), .resync(a_rsy));

  ulpi_op_assembler #(.MSG_BYTES(B_BYTES), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) u_b (
    .clk(clk), .rst(rst), .uart_data(b_data), .uart_rx_empty(b_rxe), .uart_nxt(b_nxt),
    .op_pull(b_pull), .op_msg(b_msg), .op_full(b_full), .op_empty(b_emp), .op_count(b_cnt),
    .overflow(b_ovf), .overflow_clr(b_clr), .resync(b_rsy));

  // UART Rx buffers: head byte presented on the falling edge, popped on uart_nxt.
  logic [7:0] qa[$], qb[$];
  int a_nxt_n = 0, b_nxt_n = 0, a_rsy_n = 0;

  always @(posedge clk) begin
    if (a_nxt) begin a_nxt_n++; if (qa.size() != 0) qa.delete(0); end
    if (b_nxt) begin b_nxt_n++; if (qb.size() != 0) qb.delete(0); end
    if (a_rsy) a_rsy_n++;
  end

  always @(negedge clk) begin
    a_rxe  = (qa.size() == 0);
    a_data = (qa.size() != 0) ? qa[0] : 8'h00;
    b_rxe  = (qb.size() == 0);
    b_data = (qb.size() != 0) ? qb[0] : 8'h00;
  end

  // Message-level model: queued words, last word read, sticky overflow.
  logic [63:0] ea[$], eb[$];
  logic [63:0] a_last = 64'd0, b_last = 64'd0;
  logic        a_ovf_m = 1'b0, b_ovf_m = 1'b0;
  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input bit on_b, input logic [63:0] w);
    logic [63:0] wm;
    int nb;
    nb = on_b ? int'(B_BYTES) : int'(A_BYTES);
    wm = on_b ? {32'd0, w[31:0]} : {48'd0, w[15:0]};
    for (int i = nb - 1; i >= 0; i--) begin
      if (on_b) qb.push_back(wm[8*i +: 8]);
      else      qa.push_back(wm[8*i +: 8]);
    end
    if (on_b) begin
      if (eb.size() < int'(DEPTH)) eb.push_back(wm); else b_ovf_m = 1'b1;
    end else begin
      if (ea.size() < int'(DEPTH)) ea.push_back(wm); else a_ovf_m = 1'b1;
    end
  endtask

  task automatic wait_drain(input bit on_b);
    int n;
    n = 0;
    while ((on_b ? qb.size() : qa.size()) != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(on_b ? "drain_b" : "drain_a", 64'(on_b ? qb.size() : qa.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic pull(input bit on_b);
    @(negedge clk);
    if (on_b) b_pull = 1'b1; else a_pull = 1'b1;
    @(negedge clk);
    a_pull = 1'b0;
    b_pull = 1'b0;
    if (on_b) begin
      if (eb.size() != 0) b_last = eb.pop_front();
      check("pull_b_msg", 64'(b_msg), b_last);
      check("pull_b_count", 64'(b_cnt), 64'(eb.size()));
    end else begin
      if (ea.size() != 0) a_last = ea.pop_front();
      check("pull_a_msg", 64'(a_msg), a_last);
      check("pull_a_count", 64'(a_cnt), 64'(ea.size()));
    end
  endtask

  task automatic reset_check();
    check("rst_a_msg", 64'(a_msg), 64'd0);    check("rst_b_msg", 64'(b_msg), 64'd0);
    check("rst_a_count", 64'(a_cnt), 64'd0);  check("rst_b_count", 64'(b_cnt), 64'd0);
    check("rst_a_empty", 64'(a_emp), 64'd1);  check("rst_b_empty", 64'(b_emp), 64'd1);
    check("rst_a_full", 64'(a_full), 64'd0);  check("rst_b_full", 64'(b_full), 64'd0);
    check("rst_a_ovf", 64'(a_ovf), 64'd0);    check("rst_b_ovf", 64'(b_ovf), 64'd0);
    check("rst_a_nxt", 64'(a_nxt), 64'd0);    check("rst_b_nxt", 64'(b_nxt), 64'd0);
    check("rst_a_resync", 64'(a_rsy), 64'd0); check("rst_b_resync", 64'(b_rsy), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, n, nmsg, k, exp_rsy;

    repeat (3) @(negedge clk);
    reset_check();
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Two bytes build one word, two pops.
    base = a_nxt_n;
    send(1'b0, 64'hA53C);
    wait_drain(1'b0);
    check("basic_nxt_pulses", 64'(a_nxt_n - base), 64'd2);
    check("basic_count", 64'(a_cnt), 64'd1);
    check("basic_empty", 64'(a_emp), 64'd0);
    pull(1'b0);

    // Ordered reads, then a read while empty changes nothing.
    send(1'b0, 64'h1111);
    send(1'b0, 64'h2222);
    wait_drain(1'b0);
    pull(1'b0);
    pull(1'b0);
    pull(1'b0);
    check("empty_pull_flag", 64'(a_emp), 64'd1);
    send(1'b0, 64'h4242);
    wait_drain(1'b0);
    pull(1'b0);

    // Pull aligned with the PUSH cycle at count 2.
    send(1'b0, 64'h0101);
    send(1'b0, 64'h0202);
    wait_drain(1'b0);
    check("sim_pre_count", 64'(a_cnt), 64'd2);
    base = a_nxt_n;
    qa.push_back(8'h03);
    qa.push_back(8'h04);
    n = 0;
    while (a_nxt_n < base + 2 && n < 200) begin @(negedge clk); n++; end
    check("sim_push_window", 64'(a_nxt_n - base), 64'd2);
    a_pull = 1'b1;
    @(negedge clk);
    a_pull = 1'b0;
    ea.push_back(64'h0304);
    a_last = ea.pop_front();
    check("sim_msg", 64'(a_msg), a_last);
    check("sim_count", 64'(a_cnt), 64'd2);
    pull(1'b0);
    pull(1'b0);

    // 3*DEPTH messages through the FIFO to exercise pointer wrap.
    for (int i = 0; i < 3 * int'(DEPTH); i++) begin
      send(1'b0, 64'($urandom));
      wait_drain(1'b0);
      pull(1'b0);
    end

    // Random bursts with overflow and partial drains.
    for (int r = 0; r < 5; r++) begin
      nmsg = int'($urandom_range(DEPTH + 2, 1));
      for (int i = 0; i < nmsg; i++) send(1'b0, 64'($urandom));
      wait_drain(1'b0);
      check("rnd_count", 64'(a_cnt), 64'(ea.size()));
      check("rnd_full", 64'(a_full), 64'(ea.size() == int'(DEPTH)));
      check("rnd_ovf", 64'(a_ovf), 64'(a_ovf_m));
      a_clr = 1'b1;
      @(negedge clk);
      a_clr = 1'b0;
      a_ovf_m = 1'b0;
      check("rnd_ovf_clr", 64'(a_ovf), 64'd0);
      k = int'($urandom_range(ea.size(), 0));
      for (int i = 0; i < k; i++) pull(1'b0);
    end
    while (ea.size() != 0) pull(1'b0);

    // Four-byte messages into a depth-4 FIFO: fifth one dropped.
    for (int i = 0; i < 5; i++) send(1'b1, 64'($urandom));
    wait_drain(1'b1);
    check("ovf_b_count", 64'(b_cnt), 64'd4);
    check("ovf_b_full", 64'(b_full), 64'd1);
    check("ovf_b_flag", 64'(b_ovf), 64'(b_ovf_m));
    b_clr = 1'b1;
    @(negedge clk);
    b_clr = 1'b0;
    b_ovf_m = 1'b0;
    check("ovf_b_clr", 64'(b_ovf), 64'd0);

    // Drop in the same cycle as overflow_clr: the set wins.
    b_clr = 1'b1;
    base = b_nxt_n;
    send(1'b1, 64'($urandom));
    n = 0;
    while (b_nxt_n < base + int'(B_BYTES) && n < 200) begin @(negedge clk); n++; end
    check("setwins_window", 64'(b_nxt_n - base), 64'(B_BYTES));
    @(negedge clk);
    b_clr = 1'b0;
    check("setwins_ovf", 64'(b_ovf), 64'(b_ovf_m));
    check("setwins_count", 64'(b_cnt), 64'd4);
    pull(1'b1);
    pull(1'b1);

    // Reset between the first and second byte of a message.
    send(1'b0, 64'h1234);
    wait_drain(1'b0);
    qa.push_back(8'hAA);
    wait_drain(1'b0);
    rst = 1'b0;
    @(negedge clk);
    reset_check();
    rst = 1'b1;
    ea.delete();
    eb.delete();
    a_last = 64'd0;
    b_last = 64'd0;
    a_ovf_m = 1'b0;
    b_ovf_m = 1'b0;
    @(negedge clk);
    send(1'b0, 64'hBEEF);
    wait_drain(1'b0);
    check("post_rst_count", 64'(a_cnt), 64'd1);
    pull(1'b0);

    // Idle gap longer than TIMEOUT_CYCLES after one byte.
    base = a_rsy_n;
    qa.push_back(8'h11);
    wait_drain(1'b0);
    repeat (12) @(negedge clk);
    qa.push_back(8'h22);
    qa.push_back(8'h33);
    wait_drain(1'b0);
`ifdef ULPI_OP_ASM_TIMEOUT_EN
    ea.push_back(64'h2233);
    exp_rsy = 1;
`else
    ea.push_back(64'h1122);
    exp_rsy = 0;
`endif
    check("timeout_resync_pulses", 64'(a_rsy_n - base), 64'(exp_rsy));
    check("timeout_count", 64'(a_cnt), 64'd1);
    pull(1'b0);
    check("b_resync_idle", 64'(b_rsy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ulpi_op_assembler.md
ULPI_OP_ASSEMBLER -- requirements
Module: ulpi_op_assembler

Interface
REQ-001 Parameter MSG_BYTES, default 2, UART bytes per operation message (range 1..8).
REQ-002 Parameter DEPTH, default 16, message FIFO depth in words (power of 2, at least 2).
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, inter-byte idle limit in clk cycles (used only with REQ-026).
REQ-004 clk  in  1  reference clock; all logic on its rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-low.
REQ-006 uart_data  in  8  head byte of the UART Rx buffer.
REQ-007 uart_rx_empty  in  1  high when the UART Rx buffer holds no byte.
REQ-008 uart_nxt  out  1  one-cycle pop strobe to the UART Rx buffer.
REQ-009 op_pull  in  1  read request for one message word.
REQ-010 op_msg  out  8*MSG_BYTES  message word read from the FIFO.
REQ-011 op_full / op_empty  out  1 each  FIFO full / empty flags.
REQ-012 op_count  out  clog2(DEPTH)+1  number of words held.
REQ-013 overflow  out  1  sticky flag: a completed message was dropped.
REQ-014 overflow_clr  in  1  clears overflow.
REQ-015 resync  out  1  one-cycle pulse: partial message discarded by timeout.

Function
REQ-016 Assembler FSM states: IDLE, READ, PUSH.
REQ-017 IDLE -> READ when uart_rx_empty is low; otherwise stay in IDLE.
REQ-018 uart_nxt SHALL be high exactly while in READ; one byte is consumed per READ cycle.
REQ-019 In READ: uart_data is stored in byte slot idx, MSB-first (idx 0 -> op_msg[8*MSG_BYTES-1 -: 8]); idx increments; if idx == MSG_BYTES-1 go to PUSH, else go to IDLE.
REQ-020 In PUSH: if op_full is low, the assembled word is written to the FIFO; if op_full is high, the word is discarded and overflow is set; in both cases idx <= 0 and next state is IDLE.
REQ-021 Throughput: at most one byte per 2 cycles; a message reaches the FIFO 1 cycle after its last READ.
REQ-022 FIFO read: op_pull with op_empty low pops one word; op_msg updates on the following clock edge (1-cycle read latency) and holds its value otherwise; op_pull with op_empty high is ignored.
REQ-023 The full/empty decision in PUSH uses flags registered before the edge; a simultaneous op_pull does not rescue a push to a full FIFO.
REQ-024 Simultaneous accepted write and read: op_count is unchanged and pointers both advance; pointers wrap modulo DEPTH.
REQ-025 overflow_clr clears overflow; if a drop occurs in the same cycle, the set wins.

Configuration
REQ-026 Macro ULPI_OP_ASM_TIMEOUT_EN defined: a counter runs while idx != 0 and the FSM is in IDLE, and it restarts on each READ. On reaching TIMEOUT_CYCLES, idx <= 0, resync pulses for 1 cycle, and the counter clears; slot contents are not cleared.
REQ-027 Macro undefined: no counter is built, resync is tied low, and partial messages wait indefinitely.

Reset
REQ-028 On rst low: FSM = IDLE, idx = 0, assembly register = 0, FIFO pointers = 0, op_count = 0, op_empty = 1, op_full = 0, op_msg = 0, overflow = 0, uart_nxt = 0, resync = 0, timeout counter = 0.
REQ-029 Reset mid-message discards the partial message and all FIFO contents; the first byte after release goes into slot 0.

Structure
REQ-030 The shared package holds the FSM state encodings, the MSG_BYTES range limits and the clog2 helper.
REQ-031 The FIFO is one sub-module, ulpi_op_fifo, parametrised by width and depth, with registered read data and full/empty/count outputs; the FSM and the assembly register stay in the top level.

Verification
REQ-032 MSG_BYTES=2: bytes 0xA5, 0x3C -> one FIFO word 0xA53C; exactly 2 uart_nxt pulses; op_count=1.
REQ-033 MSG_BYTES=4, DEPTH=4: 5 messages, no pulls -> 4 stored; the fifth is dropped, overflow=1, op_count=4; overflow_clr -> overflow=0.
REQ-034 Pull on a FIFO holding 0x1111 and 0x2222 -> op_msg=0x1111 one cycle after the first pull, then 0x2222; a pull while empty leaves op_msg and the pointers unchanged.
REQ-035 Push and pull in the same cycle on a FIFO with op_count=2 -> op_count stays 2; also run 3*DEPTH messages through the FIFO to confirm pointer wrap-around.
REQ-036 With ULPI_OP_ASM_TIMEOUT_EN and TIMEOUT_CYCLES=8: byte 0x11, 8 idle cycles, then 0x22, 0x33 -> resync pulses once and the stored word is 0x2233; with the macro undefined the stored word is 0x1122.
REQ-037 Assert rst between the first and second byte -> all outputs take their REQ-028 values; the next 2 bytes 0xBE, 0xEF -> word 0xBEEF.
